toggle_event_decoder: RTL and testbench
=======================================

// Module: toggle_event_decoder
// PURPOSE
// - Converts a sampled level bus into per-bit toggle commands: tog = level(now) ^ level(prev).
//   This is the inverse of the D-from-T register, which builds level storage from toggle cells.
// - Buffers non-zero toggle words in a small FIFO and delivers them over a valid/ready interface.
// - Sits between a level-producing register bank and any toggle-cell consumer, such as a TFF bank or a replay engine.
// PARAMETERS
// - WIDTH  8   bits per level/toggle word
// - DEPTH  4   FIFO entries; power of 2, >= 2
// - CNT_W  16  width of the accepted-event counter
// PORTS
// - CLK         in   1                  sole clock; all state updates on posedge
// - reset       in   1                  synchronous, active-high
// - lvl_in      in   WIDTH              level word to sample
// - lvl_en      in   1                  qualifies lvl_in on this edge
// - tog_out     out  WIDTH              head-of-FIFO toggle word
// - tog_valid   out  1                  tog_out holds a valid word
// - tog_ready   in   1                  consumer accepts tog_out this cycle
// - level_q     out  WIDTH              last sampled level (prev register)
// - fifo_count  out  $clog2(DEPTH)+1    current number of occupied entries
// - event_cnt   out  CNT_W              accepted (pushed) events, saturating
// - overflow    out  1                  sticky; set when an event is dropped
// BEHAVIOUR
// - Interface decision: one clock, CLK; reset is synchronous and active-high, port named reset.
// - Reset values: prev/level_q=0, primed=0, FIFO empty, fifo_count=0, tog_valid=0, tog_out=0,
//   event_cnt=0, overflow=0.
// - Priming: the first lvl_en after reset loads prev<=lvl_in and sets primed=1. No event is generated.
// - Sampling when primed: diff=lvl_in^prev and prev<=lvl_in on every lvl_en edge.
//   - Push diff only if diff!=0.
//   - Identical samples produce nothing.
// - lvl_en=0: prev holds and no push occurs.
// - Latency: diff sampled at edge k into an empty FIFO gives tog_valid=1 and tog_out=diff in the cycle after edge k.
// - Pop: occurs on any edge where tog_valid&&tog_ready.
//   - tog_out and tog_valid stay stable while tog_valid&&!tog_ready.
// - Ordering: strict FIFO. Pointers wrap modulo DEPTH.
// - Full, push with no pop: the word is dropped and overflow<=1. prev still updates. event_cnt unchanged.
// - Full, push with pop on the same edge: both happen and fifo_count stays DEPTH. Not an overflow.
// - Empty, push with tog_ready=1: no bypass; the word appears the next cycle.
// - event_cnt: +1 per accepted push; holds at {CNT_W{1'b1}}.
// - overflow: cleared only by reset.
// - Reset mid-operation: FIFO is flushed, queued words are lost, primed=0.
//   The next lvl_en re-primes the block.
// - Invariant: if overflow==0, the primed level XOR all popped words XOR all queued words equals level_q.
// STRUCTURE
// - Package toggle_pkg holds:
//   - the FIFO pointer-width function (clog2), and
//   - the saturating-increment constant/function shared with other counters in the FlipFlops set.
// - One sub-module: toggle_fifo, a synchronous DEPTH x WIDTH FIFO.
//   - Ports: push, pop, din, dout, empty, full, count.
//   - Registered head output; same-edge push+pop supported.
// - Top level contains: prev/primed registers, diff/XOR logic, push gating, event_cnt, overflow.
// TESTING
// 1. Reset, then lvl_en with 8'hA5 -> no tog_valid; level_q=A5.
//    Next lvl_en with 8'hA4 -> tog_out=01 and tog_valid=1 one cycle later; event_cnt=1.
// 2. Repeated identical samples 8'h3C x10 after priming -> tog_valid stays 0; event_cnt unchanged.
// 3. tog_ready=0, DEPTH=4, push 5 distinct changes -> fifo_count=4, overflow=1, event_cnt=4.
//    Then tog_ready=1 -> the first 4 words pop in push order.
// 4. FIFO full; on the same edge, tog_ready=1 and a new change arrives -> no overflow, fifo_count stays 4,
//    and the new word comes out last.
// 5. Reset asserted with 3 words queued -> next cycle tog_valid=0, fifo_count=0, event_cnt=0, overflow=0.
//    The next lvl_en primes only and does not push.
// 6. Random lvl_in/lvl_en/tog_ready for 10k cycles, overflow never set ->
//    XOR reconstruction from popped plus queued words matches level_q every cycle.

Source files
------------

// File: rtl/toggle_pkg.sv
// rtl/toggle_pkg.sv - shared sizing and saturating-counter helpers
package toggle_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Saturation ceiling of a w-bit counter, carried in 32 bits so any width up to 32 fits.
  function automatic logic [31:0] sat_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic bit sat_hit(input logic [31:0] v, input int w);
    return v == sat_max(w);
  endfunction

endpackage

// File: rtl/toggle_fifo.sv
// rtl/toggle_fifo.sv - synchronous DEPTH x WIDTH FIFO with registered head output
module toggle_fifo
  import toggle_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      // The write slot meets the next head only when the new word is the sole entry.
      if (do_push && (wr_ptr == rd_next)) dout <= din;
      else                                dout <= mem[rd_next];
    end
  end

endmodule

// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - turns sampled level words into queued toggle words
module toggle_event_decoder
  import toggle_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       lvl_in,
  input  logic                   lvl_en,
  output logic [WIDTH-1:0]       tog_out,
  output logic                   tog_valid,
  input  logic                   tog_ready,
  output logic [WIDTH-1:0]       level_q,
  output logic [clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]       event_cnt,
  output logic                   overflow
);

  logic [WIDTH-1:0] prev, diff;
  logic             primed;
  logic             fifo_empty, fifo_full;
  logic             pop, want_push, do_push;

  assign diff      = lvl_in ^ prev;
  assign pop       = tog_valid && tog_ready;
  assign want_push = lvl_en && primed && (diff != '0);
  // A full FIFO still accepts when its head leaves on the same edge.
  assign do_push   = want_push && (!fifo_full || pop);
  assign tog_valid = !fifo_empty;
  assign level_q   = prev;

  always_ff @(posedge CLK) begin
    if (reset) begin
      prev      <= '0;
      primed    <= 1'b0;
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (lvl_en) begin
        prev   <= lvl_in;
        primed <= 1'b1;
      end
      if (do_push && !sat_hit(32'(event_cnt), CNT_W))
        event_cnt <= event_cnt + CNT_W'(1);
      if (want_push && !do_push)
        overflow <= 1'b1;
    end
  end

  toggle_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (do_push),
    .pop   (pop),
    .din   (diff),
    .dout  (tog_out),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - randomized and directed bench with a queue-based reference model
module tb_toggle_event_decoder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] lvl_in;
  logic             lvl_en;
  logic [WIDTH-1:0] tog_out;
  logic             tog_valid;
  logic             tog_ready;
  logic [WIDTH-1:0] level_q;
  logic [2:0]       fifo_count;
  logic [CNT_W-1:0] event_cnt;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of pending toggle words plus scalar state.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_prev;
  bit               m_primed;
  int               m_cnt;
  bit               m_ovf;

  always #5 CLK = ~CLK;

  toggle_event_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .lvl_in     (lvl_in),
    .lvl_en     (lvl_en),
    .tog_out    (tog_out),
    .tog_valid  (tog_valid),
    .tog_ready  (tog_ready),
    .level_q    (level_q),
    .fifo_count (fifo_count),
    .event_cnt  (event_cnt),
    .overflow   (overflow)
  );

  // Drive one cycle of inputs, advance the model by the same rules, then step past the edge.
  task automatic cycle(input bit r, input bit en, input logic [WIDTH-1:0] lvl, input bit rdy);
    logic [WIDTH-1:0] d;
    bit pop;
    reset = r; lvl_en = en; lvl_in = lvl; tog_ready = rdy;
    if (r) begin
      mq.delete(); m_prev = '0; m_primed = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (en) begin
        if (!m_primed) begin
          m_primed = 1;
        end else begin
          d = lvl ^ m_prev;
          if (d != 0) begin
            if (mq.size() < DEPTH) begin
              mq.push_back(d);
              if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else begin
              m_ovf = 1;
            end
          end
        end
        m_prev = lvl;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 8'h00, 0);
    cycle(1, 1, 8'hFF, 1);
    cycle(0, 0, 8'h00, 0);
    checks++; if (tog_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tog_valid); end
    checks++; if (tog_out !== 8'h00) begin errors++; $display("FAIL reset_tog_out: got %h want 00", tog_out); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (event_cnt !== 16'd0 || overflow !== 1'b0 || level_q !== 8'h00) begin
      errors++; $display("FAIL reset_state: cnt %0d ovf %b lvl %h want 0 0 00", event_cnt, overflow, level_q);
    end
  endtask

  task automatic test_prime_and_first_event;
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'hA5, 0);
    checks++; if (tog_valid !== 1'b0) begin errors++; $display("FAIL prime_valid: got %b want 0", tog_valid); end
    checks++; if (level_q !== 8'hA5) begin errors++; $display("FAIL prime_level: got %h want a5", level_q); end
    cycle(0, 1, 8'hA4, 0);
    checks++; if (tog_valid !== 1'b1 || tog_out !== 8'h01) begin
      errors++; $display("FAIL first_event: valid %b tog %h want 1 01", tog_valid, tog_out);
    end
    checks++; if (event_cnt !== 16'd1) begin errors++; $display("FAIL first_event_cnt: got %0d want 1", event_cnt); end
  endtask

  task automatic test_identical_samples;
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h3C, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'h3C, 1);
      checks++; if (tog_valid !== 1'b0) begin errors++; $display("FAIL identical_valid[%0d]: got %b want 0", i, tog_valid); end
    end
    checks++; if (event_cnt !== 16'd0) begin errors++; $display("FAIL identical_cnt: got %0d want 0", event_cnt); end
  endtask

  task automatic test_overflow;
    logic [WIDTH-1:0] lv [5];
    logic [WIDTH-1:0] exp_w [4];
    lv = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    exp_w = '{8'h01, 8'h02, 8'h04, 8'h08};
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, lv[i], 0);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (event_cnt !== 16'd4) begin errors++; $display("FAIL ovf_cnt: got %0d want 4", event_cnt); end
    checks++; if (level_q !== 8'h1F) begin errors++; $display("FAIL ovf_level: got %h want 1f", level_q); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (tog_valid !== 1'b1 || tog_out !== exp_w[i]) begin
        errors++; $display("FAIL ovf_drain[%0d]: valid %b tog %h want 1 %h", i, tog_valid, tog_out, exp_w[i]);
      end
      cycle(0, 0, 8'h00, 1);
    end
    checks++; if (tog_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", tog_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [WIDTH-1:0] exp_w [4];
    exp_w = '{8'h02, 8'h04, 8'h08, 8'h80};
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 1, 8'h01, 0);
    cycle(0, 1, 8'h03, 0);
    cycle(0, 1, 8'h07, 0);
    cycle(0, 1, 8'h0F, 0);
    // Stall check: head must hold while the consumer is not ready.
    cycle(0, 0, 8'h0F, 0);
    checks++; if (tog_out !== 8'h01 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL full_stall: tog %h count %0d want 01 4", tog_out, fifo_count);
    end
    cycle(0, 1, 8'h8F, 1);
    checks++; if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL full_pushpop: ovf %b count %0d want 0 4", overflow, fifo_count);
    end
    checks++; if (event_cnt !== 16'd5) begin errors++; $display("FAIL full_pushpop_cnt: got %0d want 5", event_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (tog_valid !== 1'b1 || tog_out !== exp_w[i]) begin
        errors++; $display("FAIL full_drain[%0d]: valid %b tog %h want 1 %h", i, tog_valid, tog_out, exp_w[i]);
      end
      cycle(0, 0, 8'h00, 1);
    end
  endtask

  task automatic test_reset_mid_operation;
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, 8'h10, 0);
    cycle(0, 1, 8'h11, 0);
    cycle(0, 1, 8'h13, 0);
    cycle(0, 1, 8'h17, 0);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL midrst_pre: got %0d want 3", fifo_count); end
    cycle(1, 1, 8'h99, 1);
    checks++; if (tog_valid !== 1'b0 || fifo_count !== 3'd0 || event_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_flush: valid %b count %0d cnt %0d ovf %b want 0 0 0 0", tog_valid, fifo_count, event_cnt, overflow);
    end
    cycle(0, 1, 8'h55, 0);
    checks++; if (tog_valid !== 1'b0 || fifo_count !== 3'd0 || level_q !== 8'h55) begin
      errors++; $display("FAIL midrst_reprime: valid %b count %0d lvl %h want 0 0 55", tog_valid, fifo_count, level_q);
    end
  endtask

  // Random traffic with overflow avoided; level is rebuilt from the primed level and all toggle words.
  task automatic test_random;
    logic [WIDTH-1:0] primed_level, popped_xor, queued_xor, lvl;
    bit en, rdy, was_primed;
    cycle(1, 0, 8'h00, 0);
    primed_level = '0; popped_xor = '0;
    for (int n = 0; n < 10000; n++) begin
      en  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      lvl = ($urandom_range(0, 3) == 0) ? m_prev : WIDTH'($urandom);
      if (mq.size() == DEPTH && en && m_primed && lvl != m_prev) rdy = 1;
      if (tog_valid && rdy) popped_xor ^= tog_out;
      was_primed = m_primed;
      if (en && !was_primed) begin primed_level = lvl; popped_xor = '0; end
      cycle(0, en, lvl, rdy);
      queued_xor = '0;
      foreach (mq[k]) queued_xor ^= mq[k];
      checks++; if (tog_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, tog_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (tog_out !== mq[0]) begin errors++; $display("FAIL rnd_tog@%0d: got %h want %h", n, tog_out, mq[0]); end
      end
      checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, fifo_count, mq.size()); end
      checks++; if (event_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, event_cnt, m_cnt); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want 0", n, overflow); end
      if (m_primed) begin
        checks++; if (level_q !== (primed_level ^ popped_xor ^ queued_xor)) begin
          errors++; $display("FAIL rnd_xor@%0d: level_q %h want %h", n, level_q, primed_level ^ popped_xor ^ queued_xor);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; lvl_en = 1'b0; lvl_in = '0; tog_ready = 1'b0;
    test_reset();
    test_prime_and_first_event();
    test_identical_samples();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_operation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
